ahb_sram_slave: RTL and testbench

AHB-lite single-port SRAM slave sitting directly downstream of the CPU memory access unit on the simplified AHB bus. It consumes the unit's address/control/write-data phases and returns HRDATA/HREADY/HRESP.
- Configurable wait states.
- Byte-lane writes derived from HSIZE/HADDR.
- Returns the full aligned word on reads; the master does lane extraction and sign extension.
- Gives a two-cycle ERROR response for unaligned, oversize or out-of-range transfers.

---
 rtl/ahb_pkg.sv | 37 +++
 rtl/sram_be_bank.sv | 37 +++
 rtl/ahb_sram_slave.sv | 148 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-lite codes and lane-mask helper, reused by the CPU memory access unit.
package ahb_pkg;

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespError = 2'b01;
  localparam logic [1:0] RespRetry = 2'b10;
  localparam logic [1:0] RespSplit = 2'b11;

  localparam logic [2:0] SizeByte = 3'b000;
  localparam logic [2:0] SizeHalf = 3'b001;
  localparam logic [2:0] SizeWord = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StLast,
    StErr1,
    StErr2
  } slave_state_e;

  // Byte lanes touched by a transfer; oversize codes fall through to a full word.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] m;
    case (size)
      SizeByte: m = 4'b0001 << addr;
      SizeHalf: m = addr[1] ? 4'b1100 : 4'b0011;
      default:  m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sram_be_bank.sv
// Single-port word RAM: synchronous read, byte-enable synchronous write, read-old-data.
module sram_be_bank #(
  parameter int unsigned AddrWidth = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 re,
  input  logic [AddrWidth-1:0] raddr,
  output logic [31:0]          rdata,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [3:0]           wmask,
  input  logic [31:0]          wdata
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [31:0] mem [Depth];

  // Output register is reset; the array itself is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'h0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave with configurable wait states, byte-lane writes and a
// two-cycle ERROR response for misaligned, oversize or out-of-region transfers.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBUST,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);

  localparam logic [2:0] WaitCnt = 3'(WAIT_STATES);

  slave_state_e          state_q;
  logic [2:0]            cnt_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [3:0]            mask_q;
  logic                  hready_q;
  logic [1:0]            hresp_q;
  logic [3:0]            byp_mask_q;
  logic [31:0]           byp_data_q;

  logic                  accept;
  logic                  addr_err;
  logic                  commit;
  logic                  rd_start;
  logic                  bypass;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           bank_rdata;
  logic [31:0]           byp_bits;
  logic                  unused_inputs;

  assign unused_inputs = ^{HTRANS[0], HBUST};

  assign accept  = HSEL && HTRANS[1] && hready_q;
  assign acc_idx = HADDR[ADDR_WIDTH+1:2];

  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > SizeWord) addr_err = 1'b1;
    if ((HSIZE == SizeWord) && (HADDR[1:0] != 2'b00)) addr_err = 1'b1;
    if ((HSIZE == SizeHalf) && HADDR[0]) addr_err = 1'b1;
    if (HADDR[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]) addr_err = 1'b1;
  end

  assign commit   = (state_q == StLast) && write_q;
  assign rd_start = accept && !addr_err && !HWRITE;
  // A read accepted on the edge that commits a write to the same word must see the new lanes.
  assign bypass   = commit && rd_start && (idx_q == acc_idx);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      mask_q   <= 4'b0;
      hready_q <= 1'b1;
      hresp_q  <= RespOkay;
    end else begin
      case (state_q)
        StWait: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q  <= StLast;
            hready_q <= 1'b1;
          end
        end
        StErr1: begin
          state_q  <= StErr2;
          hready_q <= 1'b1;
        end
        default: begin
          // Idle, Last and Err2 all accept a new address phase the same way.
          if (accept) begin
            write_q <= HWRITE;
            idx_q   <= acc_idx;
            mask_q  <= lane_mask(HSIZE, HADDR[1:0]);
            if (addr_err) begin
              state_q  <= StErr1;
              hready_q <= 1'b0;
              hresp_q  <= RespError;
            end else if (WAIT_STATES > 0) begin
              state_q  <= StWait;
              cnt_q    <= WaitCnt;
              hready_q <= 1'b0;
              hresp_q  <= RespOkay;
            end else begin
              state_q  <= StLast;
              hready_q <= 1'b1;
              hresp_q  <= RespOkay;
            end
          end else begin
            state_q  <= StIdle;
            hready_q <= 1'b1;
            hresp_q  <= RespOkay;
          end
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      byp_mask_q <= 4'b0;
      byp_data_q <= 32'h0;
    end else if (rd_start) begin
      byp_mask_q <= bypass ? mask_q : 4'b0;
      byp_data_q <= HWDATA;
    end
  end

  sram_be_bank #(
    .AddrWidth(ADDR_WIDTH)
  ) u_bank (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .re   (rd_start),
    .raddr(acc_idx),
    .rdata(bank_rdata),
    .we   (commit),
    .waddr(idx_q),
    .wmask(mask_q),
    .wdata(HWDATA)
  );

  assign byp_bits = {{8{byp_mask_q[3]}}, {8{byp_mask_q[2]}}, {8{byp_mask_q[1]}},
                     {8{byp_mask_q[0]}}};

  assign HRDATA = ((state_q == StLast) && !write_q) ?
                  ((bank_rdata & ~byp_bits) | (byp_data_q & byp_bits)) : 32'h0;
  assign HREADY = hready_q;
  assign HRESP  = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: three slaves (0/1/3 wait states) share one bus; a word model feeds a scoreboard.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] rd  [3];
  logic        rdy [3];
  logic [1:0]  rsp [3];

  always #5 clk = ~clk;

  // Index 0: WAIT_STATES=1, index 1: WAIT_STATES=0, index 2: WAIT_STATES=3.
  ahb_sram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_ws1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBUST(3'b000), .HWDATA(hwdata),
    .HRDATA(rd[0]), .HREADY(rdy[0]), .HRESP(rsp[0])
  );
  ahb_sram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBUST(3'b000), .HWDATA(hwdata),
    .HRDATA(rd[1]), .HREADY(rdy[1]), .HRESP(rsp[1])
  );
  ahb_sram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBUST(3'b000), .HWDATA(hwdata),
    .HRDATA(rd[2]), .HREADY(rdy[2]), .HRESP(rsp[2])
  );

  typedef struct {
    string       tag;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [int];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  function automatic bit mdl_err(input logic [31:0] a, input logic [2:0] s);
    return (s > 3'd2) || (s == 3'd2 && a[1:0] != 2'b00) || (s == 3'd1 && a[0]) ||
           (a[31:14] != 18'h0);
  endfunction

  function automatic logic [3:0] mdl_mask(input logic [31:0] a, input logic [2:0] s);
    if (s == 3'd0) return 4'b0001 << a[1:0];
    if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Computes the expected outcome in issue order and updates the word model.
  function automatic void push_exp(input int d, input logic wr, input logic [31:0] a,
                                   input logic [2:0] s, input logic [31:0] wd, input string tag);
    exp_t        e;
    int          k;
    logic [31:0] w;
    logic [3:0]  m;
    k      = d * 100000 + int'(a[13:2]);
    w      = mdl.exists(k) ? mdl[k] : 32'h0;
    e.tag  = tag;
    e.err  = mdl_err(a, s);
    e.rd   = !wr;
    e.data = w;
    if (!e.err && wr) begin
      m = mdl_mask(a, s);
      for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
      mdl[k] = w;
    end
    sb.push_back(e);
  endfunction

  // One transfer: address phase, then every data-phase cycle is checked.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] wd, input string tag);
    exp_t e;
    int   n;
    push_exp(d, wr, a, s, wd, tag);
    sel    = 3'b000;
    sel[d] = 1'b1;
    haddr  = a;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = s;
    @(posedge clk); #1;
    htrans = 2'b00;
    hwdata = wd;
    n = sb[0].err ? 2 : ws_of(d) + 1;
    for (int c = 1; c <= n; c++) begin
      chk({tag, " hready"}, {31'b0, rdy[d]}, {31'b0, (c == n)});
      chk({tag, " hresp"}, {30'b0, rsp[d]}, sb[0].err ? 32'd1 : 32'd0);
      if (c == n) begin
        e = sb.pop_front();
        chk({tag, " hrdata"}, rd[d], (e.rd && !e.err) ? e.data : 32'h0);
      end else begin
        chk({tag, " hrdata"}, rd[d], 32'h0);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n  = 1'b0;
    sel    = 3'b000;
    haddr  = 32'h0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b010;
    hwdata = 32'h0;

    // Reset and idle
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst hready", {31'b0, rdy[d]}, 32'd1);
      chk("rst hresp", {30'b0, rsp[d]}, 32'd0);
      chk("rst hrdata", rd[d], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sel   = 3'b111;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        chk("idle hready", {31'b0, rdy[d]}, 32'd1);
        chk("idle hresp", {30'b0, rsp[d]}, 32'd0);
        chk("idle hrdata", rd[d], 32'h0);
      end
    end

    // Word round trip on the 1-wait-state slave
    xfer(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, "rt wr");
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, "rt rd");

    // Byte and half lanes
    xfer(0, 1'b1, 32'h20, 3'b010, 32'h0, "lane clr");
    xfer(0, 1'b1, 32'h22, 3'b000, 32'h00AA0000, "lane byte");
    xfer(0, 1'b1, 32'h20, 3'b001, 32'h0000BEEF, "lane half");
    xfer(0, 1'b0, 32'h20, 3'b010, 32'h0, "lane rd");
    chk("lane model", mdl[32'h8], 32'h00AABEEF);

    // Error responses leave the SRAM untouched
    xfer(0, 1'b1, 32'h40, 3'b010, 32'h11223344, "err init40");
    xfer(0, 1'b1, 32'h00, 3'b010, 32'h55667788, "err init00");
    xfer(0, 1'b1, 32'h41, 3'b010, 32'hFFFFFFFF, "err word41");
    xfer(0, 1'b1, 32'h43, 3'b001, 32'hFFFFFFFF, "err half43");
    xfer(0, 1'b0, 32'h43, 3'b001, 32'h0, "err half43 rd");
    xfer(0, 1'b1, 32'h40, 3'b011, 32'hFFFFFFFF, "err size3");
    xfer(0, 1'b1, 32'h4000, 3'b010, 32'hFFFFFFFF, "err range");
    xfer(0, 1'b0, 32'h40, 3'b010, 32'h0, "err chk40");
    xfer(0, 1'b0, 32'h00, 3'b010, 32'h0, "err chk00");

    // Back-to-back RAW on the zero-wait-state slave
    xfer(1, 1'b1, 32'h44, 3'b010, 32'hAABBCCDD, "b2b init");
    push_exp(1, 1'b1, 32'h40, 3'b010, 32'h12345678, "b2b wr");
    push_exp(1, 1'b0, 32'h40, 3'b010, 32'h0, "b2b rd");
    push_exp(1, 1'b1, 32'h44, 3'b000, 32'h00000011, "b2b bwr");
    push_exp(1, 1'b0, 32'h44, 3'b010, 32'h0, "b2b brd");
    sel    = 3'b010;
    htrans = 2'b10;
    for (int i = 0; i < 4; i++) begin
      haddr  = (i < 2) ? 32'h40 : 32'h44;
      hwrite = (i % 2 == 0);
      hsize  = (i == 2) ? 3'b000 : 3'b010;
      @(posedge clk); #1;
      hwdata = (i == 0) ? 32'h12345678 : (i == 2) ? 32'h00000011 : 32'h0;
      e = sb.pop_front();
      chk({e.tag, " hready"}, {31'b0, rdy[1]}, 32'd1);
      chk({e.tag, " hresp"}, {30'b0, rsp[1]}, 32'd0);
      chk({e.tag, " hrdata"}, rd[1], e.rd ? e.data : 32'h0);
    end
    htrans = 2'b00;
    chk("b2b literal", mdl[100000 + 16], 32'h12345678);
    chk("b2b merge literal", mdl[100000 + 17], 32'hAABBCC11);
    @(posedge clk); #1;
    chk("b2b tail hready", {31'b0, rdy[1]}, 32'd1);
    chk("b2b tail hrdata", rd[1], 32'h0);

    // Reset during a wait-state write on the 3-wait-state slave
    xfer(2, 1'b1, 32'h8, 3'b010, 32'h0BADF00D, "mid init");
    sel    = 3'b100;
    haddr  = 32'h8;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize  = 3'b010;
    @(posedge clk); #1;
    htrans = 2'b00;
    hwdata = 32'hFFFFFFFF;
    chk("mid wait1", {31'b0, rdy[2]}, 32'd0);
    @(posedge clk); #1;
    chk("mid wait2", {31'b0, rdy[2]}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst hready", {31'b0, rdy[2]}, 32'd1);
    chk("mid rst hresp", {30'b0, rsp[2]}, 32'd0);
    chk("mid rst hrdata", rd[2], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("mid idle hready", {31'b0, rdy[2]}, 32'd1);
    end
    xfer(2, 1'b0, 32'h8, 3'b010, 32'h0, "mid rd");
    chk("mid model", mdl[200000 + 2], 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
